// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M issue/retire controller.
//   muldiv_op_e    - funct3 encoding of the M-extension ops
//   muldiv_state_e - controller FSM states (also visible on the debug port)
//   INT_MIN / ALL_ONES - operand/result constants for the divide special cases
//   ext33()        - sign- or zero-extension of a 32-bit operand to engine width
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4,
    ST_DRAIN = 3'd5
  } muldiv_state_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // Extend a 32-bit operand to the 33-bit engine width; sgn selects
  // sign extension, otherwise zero extension.
  function automatic logic [32:0] ext33(input logic [31:0] v, input logic sgn);
    return {sgn & v[31], v};
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: connection between muldiv_ctrl (master) and the Multiplier
// engine (slave).
//   Run        - controller -> engine, one-cycle start pulse
//   div        - controller -> engine, 1 = unsigned divide, 0 = signed multiply
//   opA, opB   - controller -> engine, 33-bit operands (dividend/divisor in div mode)
//   ready      - engine -> controller, engine idle / result valid
//   Aval, Bval - engine -> controller, multiply: product {Aval,Bval}[65:0];
//                divide: Aval = remainder, Bval = quotient
//   X          - engine -> controller, engine sign bit (not used by the controller)
//
// Handshake: the controller may pulse Run only while the engine is idle
// (ready=1). The engine drops ready after accepting Run and raises it again
// once Aval/Bval hold the result; opA/opB/div stay stable from Run until
// ready returns, and ready is not looked at in the cycle Run is high.
interface muldiv_ctrl_if;
  logic        Run;
  logic        div;
  logic [32:0] opA;
  logic [32:0] opB;
  logic        ready;
  logic [32:0] Aval;
  logic [32:0] Bval;
  logic        X;

  modport master (
    output Run, div, opA, opB,
    input  ready, Aval, Bval, X
  );

  modport slave (
    input  Run, div, opA, opB,
    output ready, Aval, Bval, X
  );
endinterface

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational conditional negate.
//   value - 32-bit input
//   neg   - 1: fixed = -value (two's complement), 0: fixed = value
//   fixed - 32-bit output
// Driving neg with the sign bit of value yields the absolute value; the
// magnitude of 0x80000000 comes out as 0x80000000, which is correct once
// read as an unsigned (zero-extended) number.
module muldiv_signfix (
  input  logic [31:0] value,
  input  logic        neg,
  output logic [31:0] fixed
);

  assign fixed = neg ? (~value + 32'd1) : value;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: issue/retire controller for the RV32M unit. Accepts one
// M-extension op at a time from EX, forms 33-bit engine operands, pulses Run,
// stalls until the engine reports ready, then selects and sign-corrects the
// result. Divide-by-zero and signed overflow complete without the engine.
//   Clk, Reset - clock; asynchronous active-high reset
//   req        - EX-stage op valid, held until done
//   funct3     - op select (muldiv_op_e)
//   rs1, rs2   - source operands, stable while req
//   kill       - flush, abandons the current op
//   stall      - req && !done
//   done       - one-cycle pulse, result valid
//   result     - registered 32-bit result
//   eng        - engine port (muldiv_ctrl_if master)
//   fsm_state  - current FSM state (muldiv_state_e encoding), debug only
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req,
  input  logic [2:0]    funct3,
  input  logic [31:0]   rs1,
  input  logic [31:0]   rs2,
  input  logic          kill,
  output logic          stall,
  output logic          done,
  output logic [31:0]   result,
  muldiv_ctrl_if.master eng,
  output logic [2:0]    fsm_state
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_ISSUE = ST_ISSUE;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_FIXUP = ST_FIXUP;
  localparam logic [2:0] S_DONE  = ST_DONE;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;

  logic [2:0]  state;
  logic [2:0]  state_nxt;

  // Latched op context
  logic [2:0]  op_q;
  logic        q_neg_q;   // DIV: quotient must be negated
  logic        r_neg_q;   // REM: remainder must be negated
  logic [32:0] opa_q;
  logic [32:0] opb_q;
  logic        div_q;
  logic [31:0] result_q;

  // Decode of the incoming op
  logic        in_div;
  logic        in_sdiv;
  logic        in_rem;
  logic        in_sgn_a;
  logic        in_sgn_b;
  logic        in_rs2_zero;
  logic        in_ovf;
  logic        in_special;
  logic [31:0] in_special_res;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] in_opa;
  logic [32:0] in_opb;
  logic        accept;

  assign in_div   = funct3[2];
  assign in_sdiv  = funct3[2] & ~funct3[0];              // DIV or REM
  assign in_rem   = funct3[1];                           // REM/REMU within divides
  assign in_sgn_a = ~funct3[2] & (funct3[1:0] != 2'b11); // MUL, MULH, MULHSU
  assign in_sgn_b = (funct3[2:1] == 2'b00);              // MUL, MULH

  assign in_rs2_zero = (rs2 == 32'd0);
  assign in_ovf      = in_sdiv & (rs1 == INT_MIN) & (rs2 == ALL_ONES);
  assign in_special  = in_div & (in_rs2_zero | in_ovf);

  // Divide by zero: q = all ones, r = rs1. Signed overflow: q = INT_MIN, r = 0.
  assign in_special_res = in_rem ? (in_rs2_zero ? rs1 : 32'd0)
                                 : (in_rs2_zero ? ALL_ONES : INT_MIN);

  assign accept = (state == S_IDLE) & req & ~kill;

  muldiv_signfix u_abs_a (
    .value (rs1),
    .neg   (in_sdiv & rs1[31]),
    .fixed (abs_a)
  );

  muldiv_signfix u_abs_b (
    .value (rs2),
    .neg   (in_sdiv & rs2[31]),
    .fixed (abs_b)
  );

  // The engine divides unsigned, so divides get zero-extended magnitudes and
  // the signs are reapplied in FIXUP.
  assign in_opa = in_div ? {1'b0, abs_a} : ext33(rs1, in_sgn_a);
  assign in_opb = in_div ? {1'b0, abs_b} : ext33(rs2, in_sgn_b);

  // Result selection
  logic [31:0] div_raw;
  logic        fix_neg;
  logic [31:0] div_fixed;
  logic [31:0] fixup_res;

  assign div_raw = op_q[1] ? eng.Aval[31:0] : eng.Bval[31:0];
  assign fix_neg = op_q[1] ? r_neg_q : q_neg_q;

  muldiv_signfix u_fix (
    .value (div_raw),
    .neg   (fix_neg),
    .fixed (div_fixed)
  );

  always_comb begin
    fixup_res = div_fixed;
    case (op_q)
      OP_MUL:                       fixup_res = eng.Bval[31:0];
      // product[63:32] straddles the Aval/Bval boundary at bit 33
      OP_MULH, OP_MULHSU, OP_MULHU: fixup_res = {eng.Aval[30:0], eng.Bval[32]};
      default:                      fixup_res = div_fixed;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = in_special ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        state_nxt = kill ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (kill)           state_nxt = S_DRAIN;
        else if (eng.ready) state_nxt = S_FIXUP;
      end
      S_FIXUP: begin
        state_nxt = kill ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        // Engine was started for a killed op; wait for it to go idle so a
        // new Run never lands on a busy engine.
        if (eng.ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      op_q     <= 3'd0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      opa_q    <= 33'd0;
      opb_q    <= 33'd0;
      div_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= funct3;
        q_neg_q <= in_sdiv & (rs1[31] ^ rs2[31]);
        r_neg_q <= in_sdiv & rs1[31];
        opa_q   <= in_opa;
        opb_q   <= in_opb;
        div_q   <= in_div;
        if (in_special) result_q <= in_special_res;
      end
      if ((state == S_FIXUP) && !kill) result_q <= fixup_res;
    end
  end

  assign eng.Run  = (state == S_ISSUE);
  assign eng.div  = div_q;
  assign eng.opA  = opa_q;
  assign eng.opB  = opb_q;

  assign done      = (state == S_DONE) & ~kill;
  assign stall     = req & ~done;
  assign result    = result_q;
  assign fsm_state = state;

  // Engine sign bit and the top remainder bit carry no information here.
  logic unused_eng_bits;
  assign unused_eng_bits = ^{eng.X, eng.Aval[32]};

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl with a behavioural
// Multiplier engine of random latency and an arithmetic reference model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        kill = 1'b0;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [2:0]  fsm_state;

  muldiv_ctrl_if eng_if ();

  muldiv_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .kill      (kill),
    .stall     (stall),
    .done      (done),
    .result    (result),
    .eng       (eng_if),
    .fsm_state (fsm_state)
  );

  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- engine model ----------------
  int eng_lat = 3;
  int eng_cnt;
  int overlap_cnt = 0;

  function automatic logic [65:0] eng_compute(input logic [32:0] a, input logic [32:0] b,
                                              input logic d);
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic [32:0]        q;
    logic [32:0]        r;
    if (d) begin
      q = (b == 33'd0) ? '1 : a / b;
      r = (b == 33'd0) ? a : a % b;
      return {r, q};
    end
    sa = {{33{a[32]}}, a};
    sb = {{33{b[32]}}, b};
    return sa * sb;
  endfunction

  assign eng_if.X = 1'b0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      eng_if.ready <= 1'b1;
      eng_if.Aval  <= '0;
      eng_if.Bval  <= '0;
      eng_cnt      <= 0;
    end else if (eng_if.Run) begin
      if (!eng_if.ready) overlap_cnt <= overlap_cnt + 1;
      {eng_if.Aval, eng_if.Bval} <= eng_compute(eng_if.opA, eng_if.opB, eng_if.div);
      eng_if.ready <= 1'b0;
      eng_cnt      <= eng_lat;
    end else if (!eng_if.ready) begin
      if (eng_cnt <= 1) eng_if.ready <= 1'b1;
      else              eng_cnt <= eng_cnt - 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin if (b == 32'd0) return ALL_ONES; p = 64'(sa / sb); return p[31:0]; end
      3'd5: begin if (b == 32'd0) return ALL_ONES; p = 64'(ua / ub); return p[31:0]; end
      3'd6: begin if (b == 32'd0) return a;        p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 32'd0) return a;     p = 64'(ua % ub); return p[31:0]; end
    endcase
  endfunction

  // Engine operands the controller should present for an op.
  task automatic exp_ops(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [32:0] ea, output logic [32:0] eb, output logic ed);
    longint ma;
    longint mb;
    logic [63:0] m;
    ed = f3[2];
    case (f3)
      3'd0, 3'd1: begin ea = {a[31], a}; eb = {b[31], b}; end
      3'd2:       begin ea = {a[31], a}; eb = {1'b0, b};  end
      3'd3, 3'd5, 3'd7: begin ea = {1'b0, a}; eb = {1'b0, b}; end
      default: begin
        ma = longint'($signed(a));
        mb = longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        m = 64'(ma); ea = m[32:0];
        m = 64'(mb); eb = m[32:0];
      end
    endcase
  endtask

  // ---------------- driver ----------------
  // Drives one op and follows it to done. fresh=1 means the controller is
  // known idle, so Run must appear in the cycle after req.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit fresh);
    bit          special;
    int          run_cyc;
    int          rdy_cyc;
    int          done_cyc;
    int          run_cnt;
    bit          stall_ok;
    logic [32:0] ea;
    logic [32:0] eb;
    logic        ed;
    logic [31:0] got;
    logic [31:0] exp_res;
    special = f3[2] && ((b == 32'd0) || (!f3[0] && a == INT_MIN && b == ALL_ONES));
    exp_q.push_back(ref_result(f3, a, b));
    exp_ops(f3, a, b, ea, eb, ed);
    eng_lat = int'($urandom_range(1, 6));
    run_cyc = -1; rdy_cyc = -1; done_cyc = -1; run_cnt = 0; stall_ok = 1'b1; got = '0;
    @(negedge Clk);
    req = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    #1;
    if (!stall) stall_ok = 1'b0;
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge Clk);
      if (eng_if.Run) begin
        run_cnt++;
        if (run_cyc < 0) begin
          run_cyc = cyc;
          check("opA", 64'(eng_if.opA), 64'(ea));
          check("opB", 64'(eng_if.opB), 64'(eb));
          check("div", 64'(eng_if.div), 64'(ed));
        end
      end
      if (run_cyc >= 0 && cyc > run_cyc && rdy_cyc < 0 && eng_if.ready) rdy_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        got = result;
        if (stall) stall_ok = 1'b0;
      end else if (!stall) begin
        stall_ok = 1'b0;
      end
    end
    req = 1'b0;
    exp_res = exp_q.pop_front();
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    if (done_cyc >= 0) check("result", 64'(got), 64'(exp_res));
    if (special) begin
      check("special_run_count", 64'(run_cnt), 64'd0);
      check("special_done_cycle", 64'(done_cyc), 64'd1);
    end else begin
      check("run_count", 64'(run_cnt), 64'd1);
      if (fresh) check("run_cycle", 64'(run_cyc), 64'd1);
      check("done_after_ready", 64'(done_cyc), 64'(rdy_cyc + 2));
    end
    check("stall", 64'(stall_ok), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return INT_MIN;
      2: return ALL_ONES;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int done_cnt;

    // Reset values
    #1 Reset = 1'b1;
    #1;
    check("rst_state",  64'(fsm_state),    64'(ST_IDLE));
    check("rst_run",    64'(eng_if.Run),   64'd0);
    check("rst_done",   64'(done),         64'd0);
    check("rst_div",    64'(eng_if.div),   64'd0);
    check("rst_opA",    64'(eng_if.opA),   64'd0);
    check("rst_opB",    64'(eng_if.opB),   64'd0);
    check("rst_result", 64'(result),       64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Directed cases
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(OP_MUL,    32'd12,        32'd4,         1'b1);
    run_op(OP_MULH,   32'hFFFF_FFFD, 32'd5,         1'b1);
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         1'b1);
    run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         1'b1);
    run_op(OP_DIVU,   32'd77,        32'd0,         1'b1);
    run_op(OP_REM,    INT_MIN,       ALL_ONES,      1'b1);
    run_op(OP_DIV,    INT_MIN,       ALL_ONES,      1'b1);
    run_op(OP_REMU,   32'd9,         32'd0,         1'b1);
    run_op(OP_MULHSU, ALL_ONES,      ALL_ONES,      1'b1);

    // Kill while waiting on the engine: no done, engine drained before the
    // next op is issued, next op still correct.
    eng_lat = 12;
    @(negedge Clk);
    req = 1'b1; funct3 = OP_DIV; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (done) done_cnt++;
    end
    kill = 1'b1; req = 1'b0;
    @(negedge Clk);
    kill = 1'b0;
    check("kill_to_drain", 64'(fsm_state), 64'(ST_DRAIN));
    if (done) done_cnt++;
    check("kill_no_done", 64'(done_cnt), 64'd0);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("drain_no_overlap", 64'(overlap_cnt), 64'd0);

    // Kill in DONE suppresses the done pulse
    @(negedge Clk);
    req = 1'b1; funct3 = OP_DIVU; rs1 = 32'd5; rs2 = 32'd0;
    @(negedge Clk);
    kill = 1'b1; req = 1'b0;
    #1;
    check("kill_in_done", 64'(done), 64'd0);
    @(negedge Clk);
    kill = 1'b0;
    check("kill_done_idle", 64'(fsm_state), 64'(ST_IDLE));

    // Asynchronous reset in the middle of WAIT
    eng_lat = 12;
    @(negedge Clk);
    req = 1'b1; funct3 = OP_MUL; rs1 = 32'd1234; rs2 = 32'd5678;
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("midrst_state",  64'(fsm_state),  64'(ST_IDLE));
    check("midrst_opA",    64'(eng_if.opA), 64'd0);
    check("midrst_opB",    64'(eng_if.opB), 64'd0);
    check("midrst_result", 64'(result),     64'd0);
    check("midrst_run",    64'(eng_if.Run), 64'd0);
    req = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    run_op(OP_MUL, 32'd1234, 32'd5678, 1'b1);

    // Random ops, back to back
    for (int i = 0; i < 50; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);
    end

    check("engine_overlap", 64'(overlap_cnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
